data_mem_arbiter: RTL

Shares one data-memory/cache port between two requesters: requester 0 is the load/store unit's to_mem/from_mem pair, requester 1 is a secondary master (debug or a future load/store-multiple sequencer). Requests are granted round-robin, and each request is held stable until the memory accepts it. The memory returns read responses in order, and the arbiter routes each one back to the requester that issued it, using an in-order routing FIFO.

---
 rtl/data_mem_arbiter_pkg.sv | 24 ++
 rtl/data_mem_arbiter_if.sv | 33 +++
 rtl/data_mem_arbiter_resp_route_fifo.sv | 51 +++++
 rtl/data_mem_arbiter.sv | 123 ++++++++++++
 4 files changed

// File: rtl/data_mem_arbiter_pkg.sv
// Shared types for the two-requester data-memory arbiter.
package data_mem_arbiter_pkg;

  localparam int MEM_REQUESTERS = 2;

  typedef struct packed {
    logic [0:31] address;
    logic [0:3]  write_en;
    logic [0:31] write_data;
    logic [0:3]  read_en;
    logic [0:4]  reg_addr;
  } mem_req_fields_t;

  typedef enum logic [1:0] {
    ARB_FREE  = 2'd0,
    ARB_HOLD0 = 2'd1,
    ARB_HOLD1 = 2'd2
  } arb_state_t;

  function automatic logic is_read(input logic [0:3] read_en);
    return |read_en;
  endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Request/response bundle used both between requester and arbiter and between arbiter and memory.
interface data_mem_arbiter_if #(
  parameter int RS_ID_WIDTH = 5
);
  logic                   req_valid;
  logic                   req_ready;
  logic [0:RS_ID_WIDTH-1] req_rs_id;
  logic [0:4]             req_reg_addr;
  logic [0:31]            req_address;
  logic [0:3]             req_write_en;
  logic [0:31]            req_write_data;
  logic [0:3]             req_read_en;

  logic                   resp_valid;
  logic                   resp_ready;
  logic [0:RS_ID_WIDTH-1] resp_rs_id;
  logic [0:4]             resp_reg_addr;
  logic [0:31]            resp_data;

  modport master (
    output req_valid, req_rs_id, req_reg_addr, req_address, req_write_en, req_write_data, req_read_en,
    input  req_ready,
    input  resp_valid, resp_rs_id, resp_reg_addr, resp_data,
    output resp_ready
  );

  modport slave (
    input  req_valid, req_rs_id, req_reg_addr, req_address, req_write_en, req_write_data, req_read_en,
    output req_ready,
    output resp_valid, resp_rs_id, resp_reg_addr, resp_data,
    input  resp_ready
  );
endinterface

// File: rtl/data_mem_arbiter_resp_route_fifo.sv
// In-order routing FIFO: one bit per outstanding read naming the requester that issued it.
module resp_route_fifo #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     push_data,
  input  logic                     pop,
  output logic                     pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   CNT_FULL = (PTR_W+1)'(DEPTH);

  logic [DEPTH-1:0] slots;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign do_push  = push & ~full;
  assign do_pop   = pop & ~empty;
  assign full     = (count == CNT_FULL);
  assign empty    = (count == '0);
  assign pop_data = slots[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) slots[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one memory port between two requesters, with in-order response routing.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int RS_ID_WIDTH     = 5,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                            clk,
  input  logic                            rst,
  data_mem_arbiter_if.slave               req0,
  data_mem_arbiter_if.slave               req1,
  data_mem_arbiter_if.master              mem,
  output logic [0:$clog2(MAX_OUTSTANDING)] outstanding,
  output logic                            idle,
  output logic                            err_unexpected_resp
);
  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  mem_req_fields_t           fields [MEM_REQUESTERS];
  logic [0:RS_ID_WIDTH-1]    rs_id  [MEM_REQUESTERS];
  mem_req_fields_t           sel;
  logic [MEM_REQUESTERS-1:0] valid, rd, elig;
  arb_state_t                state, state_nx;
  logic                      last_grant, winner, mem_valid, fire;
  logic                      fifo_full, fifo_empty, head, push, pop, has_route, resp_ready_mux;
  logic [CNT_W-1:0]          count;

  assign fields[0] = '{address: req0.req_address, write_en: req0.req_write_en,
                       write_data: req0.req_write_data, read_en: req0.req_read_en,
                       reg_addr: req0.req_reg_addr};
  assign fields[1] = '{address: req1.req_address, write_en: req1.req_write_en,
                       write_data: req1.req_write_data, read_en: req1.req_read_en,
                       reg_addr: req1.req_reg_addr};
  assign rs_id[0]  = req0.req_rs_id;
  assign rs_id[1]  = req1.req_rs_id;

  // A full routing FIFO blocks reads even if a slot frees this same cycle.
  assign valid = {req1.req_valid, req0.req_valid};
  assign rd    = {is_read(req1.req_read_en), is_read(req0.req_read_en)};
  assign elig  = valid & (~rd | {MEM_REQUESTERS{~fifo_full}});

  always_comb begin
    state_nx  = state;
    winner    = 1'b0;
    mem_valid = 1'b0;
    case (state)
      ARB_HOLD0: begin
        winner    = 1'b0;
        mem_valid = elig[0];
      end
      ARB_HOLD1: begin
        winner    = 1'b1;
        mem_valid = elig[1];
      end
      default: begin
        winner    = (&elig) ? ~last_grant : elig[1];
        mem_valid = |elig;
      end
    endcase
    fire = mem_valid & mem.req_ready;
    if (fire)           state_nx = ARB_FREE;
    else if (mem_valid) state_nx = winner ? ARB_HOLD1 : ARB_HOLD0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_FREE;
      last_grant <= 1'b1;
    end else begin
      state <= state_nx;
      if (fire) last_grant <= winner;
    end
  end

  assign sel                = fields[winner];
  assign mem.req_valid      = mem_valid;
  assign mem.req_rs_id      = rs_id[winner];
  assign mem.req_reg_addr   = sel.reg_addr;
  assign mem.req_address    = sel.address;
  assign mem.req_write_en   = sel.write_en;
  assign mem.req_write_data = sel.write_data;
  assign mem.req_read_en    = sel.read_en;
  assign req0.req_ready     = fire & ~winner;
  assign req1.req_ready     = fire & winner;

  assign push = fire & rd[winner];

  resp_route_fifo #(.DEPTH(MAX_OUTSTANDING)) u_route (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (winner),
    .pop       (pop),
    .pop_data  (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  // With no routing entry the beat is unexpected: accept and drop it.
  assign has_route      = ~fifo_empty;
  assign resp_ready_mux = has_route ? (head ? req1.resp_ready : req0.resp_ready) : 1'b1;
  assign mem.resp_ready = resp_ready_mux;
  assign pop            = has_route & mem.resp_valid & resp_ready_mux;

  assign req0.resp_valid    = has_route & ~head & mem.resp_valid;
  assign req1.resp_valid    = has_route & head & mem.resp_valid;
  assign req0.resp_rs_id    = mem.resp_rs_id;
  assign req1.resp_rs_id    = mem.resp_rs_id;
  assign req0.resp_reg_addr = mem.resp_reg_addr;
  assign req1.resp_reg_addr = mem.resp_reg_addr;
  assign req0.resp_data     = mem.resp_data;
  assign req1.resp_data     = mem.resp_data;

  always_ff @(posedge clk) begin
    if (rst)                                err_unexpected_resp <= 1'b0;
    else if (~has_route & mem.resp_valid)   err_unexpected_resp <= 1'b1;
  end

  assign outstanding = count;
  assign idle        = (count == '0) & (state == ARB_FREE) & ~mem_valid;

endmodule
